// File: rtl/if_id_scoreboard_stage.sv
// -----------------------------------------------------------------------------
// if_id_scoreboard_stage
//
// IF/ID pipeline register with a small destination scoreboard for a MIPS-like
// pipeline. Each accepted instruction is decoded into registered fields. Its
// destination register is pushed into a DEPTH-entry shift register that ages
// by one slot each time the stage advances. A new instruction whose sources
// match an in-flight destination is held back and a bubble is issued instead.
//
// Parameters
//   DEPTH     in-flight destination entries tracked (1..8)
//   LINK_REG  destination register written by jal
//
// Ports
//   clock       rising-edge clock
//   reset       synchronous, active-low reset
//   in_valid    fetch presents an instruction on in_instr
//   in_instr    32-bit MIPS instruction word
//   in_ready    instruction is accepted at this edge (combinational)
//   out_ready   downstream can take a new decoded instruction
//   flush       taken branch/jump: discard the current slot
//   out_valid   decoded fields hold a real instruction (0 = bubble)
//   opcode, rs, rt, rd, func, shamt, immediate, address   decoded fields
//   controller  bit7 = mem-read (lw), bits1:0 = 2'b11 for a valid instruction
//   hazard      in_instr's sources match a tracked destination (combinational)
//
// Configuration
//   IFID_BYPASS_EN  when defined, only a load in entry 0 raises hazard
//                   (load-use); every other match is assumed forwarded.
// -----------------------------------------------------------------------------
module if_id_scoreboard_stage #(
    parameter int         DEPTH    = 3,
    parameter logic [4:0] LINK_REG = 5'd31
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    input  logic        out_ready,
    input  logic        flush,
    output logic        out_valid,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  func,
    output logic [4:0]  shamt,
    output logic [15:0] immediate,
    output logic [25:0] address,
    output logic [7:0]  controller,
    output logic        hazard
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       is_load;
    } sb_entry_t;

    typedef struct packed {
        logic        valid;
        logic [7:0]  ctrl;
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  func;
        logic [4:0]  shamt;
        logic [15:0] immediate;
        logic [25:0] address;
    } out_fields_t;

    // Raw instruction fields
    logic [5:0] w_op;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic [5:0] w_fn;
    assign w_op = in_instr[31:26];
    assign w_rs = in_instr[25:21];
    assign w_rt = in_instr[20:16];
    assign w_rd = in_instr[15:11];
    assign w_fn = in_instr[5:0];

    logic        w_use_rs;
    logic        w_use_rt;
    logic        w_dest_valid;
    logic [4:0]  w_dest;
    logic        w_is_load;
    out_fields_t w_nxt;

    // Decode: source usage, destination and the field image loaded on issue.
    // NOTE: every always_comb output gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_use_rs         = 1'b0;
        w_use_rt         = 1'b0;
        w_dest_valid     = 1'b0;
        w_dest           = 5'd0;
        w_is_load        = 1'b0;
        w_nxt            = '0;
        w_nxt.valid      = 1'b1;
        w_nxt.ctrl       = 8'h03;
        w_nxt.opcode     = w_op;
        if (w_op == OP_RTYPE) begin
            w_nxt.rs    = w_rs;
            w_nxt.rt    = w_rt;
            w_nxt.rd    = w_rd;
            w_nxt.shamt = in_instr[10:6];
            w_nxt.func  = w_fn;
            if (w_fn == FN_SLL || w_fn == FN_SRL || w_fn == FN_SRA) begin
                w_use_rt = 1'b1;
            end else if (w_fn == FN_JR) begin
                w_use_rs = 1'b1;
            end else begin
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
            end
            if (w_fn != FN_JR) begin
                w_dest_valid = 1'b1;
                w_dest       = w_rd;
            end
        end else if (w_op[5:3] == 3'b001 || w_op == OP_LW) begin
            w_use_rs        = 1'b1;
            w_dest_valid    = 1'b1;
            w_dest          = w_rt;
            w_nxt.rs        = w_rs;
            w_nxt.rt        = w_rt;
            w_nxt.rd        = w_rt;
            w_nxt.immediate = in_instr[15:0];
            if (w_op == OP_LW) begin
                w_is_load  = 1'b1;
                w_nxt.ctrl = 8'h83;
            end
        end else if (w_op == OP_J || w_op == OP_JAL) begin
            w_nxt.address = in_instr[25:0];
            if (w_op == OP_JAL) begin
                w_dest_valid = 1'b1;
                w_dest       = LINK_REG;
            end
        end else begin
            w_nxt.rs        = w_rs;
            w_nxt.rt        = w_rt;
            w_nxt.immediate = in_instr[15:0];
            if (w_op == OP_BEQ || w_op == OP_BNE || w_op == OP_SW) begin
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
            end
        end
    end

    sb_entry_t        r_sb [DEPTH];
    out_fields_t      r_out;
    logic [DEPTH-1:0] w_match;
    logic             w_src_hit;

    // Register 0 is hard-wired, so it can never be a real dependency.
    always_comb begin
        w_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_match[i] = r_sb[i].valid &&
                         ((w_use_rs && (w_rs != 5'd0) && (w_rs == r_sb[i].dest)) ||
                          (w_use_rt && (w_rt != 5'd0) && (w_rt == r_sb[i].dest)));
        end
    end

`ifdef IFID_BYPASS_EN
    // Forwarding covers everything except a load still in its first slot.
    assign w_src_hit = w_match[0] && r_sb[0].is_load;
`else
    assign w_src_hit = |w_match;
`endif

    logic      w_advance;
    logic      w_issue;
    sb_entry_t w_push;

    assign hazard    = in_valid && w_src_hit;
    assign in_ready  = reset && out_ready && !hazard && !flush;
    assign w_advance = out_ready || flush;
    assign w_issue   = w_advance && in_valid && !hazard && !flush;

    // A destination of 0 is pushed as an empty slot.
    always_comb begin
        w_push         = '0;
        w_push.valid   = w_issue && w_dest_valid && (w_dest != 5'd0);
        w_push.dest    = w_push.valid ? w_dest : 5'd0;
        w_push.is_load = w_push.valid && w_is_load;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the shift below relies on that ordering.
    // NOTE: the scoreboard array is reset because its valid bits gate hazard
    // detection; stale entries after reset would stall real instructions.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_out <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_sb[i] <= '0;
            end
        end else if (w_advance) begin
            r_out <= w_issue ? w_nxt : '0;
            for (int i = DEPTH - 1; i > 0; i--) begin
                r_sb[i] <= r_sb[i-1];
            end
            r_sb[0] <= w_push;
        end
    end

    assign out_valid  = r_out.valid;
    assign controller = r_out.ctrl;
    assign opcode     = r_out.opcode;
    assign rs         = r_out.rs;
    assign rt         = r_out.rt;
    assign rd         = r_out.rd;
    assign func       = r_out.func;
    assign shamt      = r_out.shamt;
    assign immediate  = r_out.immediate;
    assign address    = r_out.address;

endmodule

// File: tb/tb_if_id_scoreboard_stage.sv
// -----------------------------------------------------------------------------
// tb_if_id_scoreboard_stage
//
// Directed bench for if_id_scoreboard_stage (DEPTH=3, LINK_REG=31). The
// stimulus process pushes the hand-computed output stream (instructions and
// bubbles) into a queue; a monitor process pops one entry at every advancing
// clock edge, checks held outputs on stalled edges and checks zeros on reset
// edges. Expectations follow IFID_BYPASS_EN if the build defines it.
// -----------------------------------------------------------------------------
module tb_if_id_scoreboard_stage;

    localparam int DEPTH = 3;

`ifdef IFID_BYPASS_EN
    localparam int NB_ADD  = 0;   // add -> dependent add
    localparam int NB_LOAD = 1;   // lw -> dependent add
    localparam int NB_JR   = 0;   // jal -> jr $31
    localparam logic HZ_ALU = 1'b0;
`else
    localparam int NB_ADD  = DEPTH;
    localparam int NB_LOAD = DEPTH;
    localparam int NB_JR   = DEPTH;
    localparam logic HZ_ALU = 1'b1;
`endif

    typedef struct packed {
        logic        valid;
        logic [7:0]  ctrl;
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  func;
        logic [4:0]  shamt;
        logic [15:0] immediate;
        logic [25:0] address;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_ready;
    logic        flush;
    logic        out_valid;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  func;
    logic [4:0]  shamt;
    logic [15:0] immediate;
    logic [25:0] address;
    logic [7:0]  controller;
    logic        hazard;

    if_id_scoreboard_stage #(.DEPTH(DEPTH), .LINK_REG(5'd31)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_ready   (in_ready),
        .out_ready  (out_ready),
        .flush      (flush),
        .out_valid  (out_valid),
        .opcode     (opcode),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .func       (func),
        .shamt      (shamt),
        .immediate  (immediate),
        .address    (address),
        .controller (controller),
        .hazard     (hazard)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Instruction encoders
    function automatic logic [31:0] r_ins(input logic [4:0] s, t, d, sh, input logic [5:0] fn);
        return {6'd0, s, t, d, sh, fn};
    endfunction
    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] s, t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction
    function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [25:0] a);
        return {op, a};
    endfunction

    // Hand-specified expected output images
    function automatic exp_t e_r(input logic [4:0] s, t, d, sh, input logic [5:0] fn);
        exp_t e = '0;
        e.valid = 1'b1; e.ctrl = 8'h03;
        e.rs = s; e.rt = t; e.rd = d; e.shamt = sh; e.func = fn;
        return e;
    endfunction
    function automatic exp_t e_i(input logic [5:0] op, input logic [4:0] s, t, d,
                                 input logic [15:0] imm, input logic [7:0] ctrl);
        exp_t e = '0;
        e.valid = 1'b1; e.ctrl = ctrl; e.opcode = op;
        e.rs = s; e.rt = t; e.rd = d; e.immediate = imm;
        return e;
    endfunction
    function automatic exp_t e_j(input logic [5:0] op, input logic [25:0] a);
        exp_t e = '0;
        e.valid = 1'b1; e.ctrl = 8'h03; e.opcode = op; e.address = a;
        return e;
    endfunction

    function automatic exp_t dut_out();
        exp_t a;
        a.valid = out_valid; a.ctrl = controller; a.opcode = opcode;
        a.rs = rs; a.rt = rt; a.rd = rd; a.func = func; a.shamt = shamt;
        a.immediate = immediate; a.address = address;
        return a;
    endfunction

    task automatic push_bubbles(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back('0);
    endtask

    // ---------------- monitor ----------------
    logic mon_rst;
    logic mon_adv;
    exp_t mon_last = '0;
    exp_t mon_exp;
    exp_t mon_act;

    always @(posedge clock) begin
        mon_rst = reset;
        mon_adv = out_ready | flush;
        #1;
        mon_act = dut_out();
        if (!mon_rst) begin
            mon_last = '0;
            check("reset_outputs", mon_act, '0);
        end else if (mon_adv) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL queue_empty: DUT advanced with nothing expected, got %h (t=%0t)", mon_act, $time);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_last = mon_exp;
                check("stream_out", mon_act, mon_exp);
            end
        end else begin
            check("hold_outputs", mon_act, mon_last);
        end
    end

    // ---------------- driver ----------------
    task automatic issue_instr(input logic [31:0] ins);
        logic acc = 1'b0;
        for (int c = 0; c < 20 && !acc; c++) begin
            @(negedge clock);
            in_valid = 1'b1; in_instr = ins; out_ready = 1'b1; flush = 1'b0;
            #1 acc = in_ready;
            @(posedge clock);
        end
        check("accepted_within_budget", acc, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
            exp_q.push_back('0);
            @(posedge clock);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held for two edges with an instruction presented.
        reset = 1'b0; in_valid = 1'b1; in_instr = r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
        out_ready = 1'b1; flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            check("in_ready_in_reset", in_ready, 1'b0);
        end
        reset = 1'b1;

        // add $3,$1,$2 issues one edge after release; add $5,$3,$4 follows.
        exp_q.push_back(e_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
        push_bubbles(NB_ADD);
        exp_q.push_back(e_r(5'd3, 5'd4, 5'd5, 5'd0, 6'h20));
        #1 check("in_ready_after_release", in_ready, 1'b1);
        @(posedge clock);
        issue_instr(r_ins(5'd3, 5'd4, 5'd5, 5'd0, 6'h20));
        idle(4);

        // Load-use: lw $4,8($1) then add $6,$4,$4.
        exp_q.push_back(e_i(6'h23, 5'd1, 5'd4, 5'd4, 16'd8, 8'h83));
        push_bubbles(NB_LOAD);
        exp_q.push_back(e_r(5'd4, 5'd4, 5'd6, 5'd0, 6'h20));
        issue_instr(i_ins(6'h23, 5'd1, 5'd4, 16'd8));
        issue_instr(r_ins(5'd4, 5'd4, 5'd6, 5'd0, 6'h20));
        idle(4);

        // Back-pressure: addi $7,$2,5 issues, then sub $9,$7,$7 waits
        // through 4 stalled clocks.
        exp_q.push_back(e_i(6'h08, 5'd2, 5'd7, 5'd7, 16'd5, 8'h03));
        push_bubbles(NB_ADD);
        exp_q.push_back(e_r(5'd7, 5'd7, 5'd9, 5'd0, 6'h22));
        issue_instr(i_ins(6'h08, 5'd2, 5'd7, 16'd5));
        @(negedge clock);
        in_valid = 1'b1; in_instr = r_ins(5'd7, 5'd7, 5'd9, 5'd0, 6'h22); out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clock);
            #1;
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_hazard", hazard, HZ_ALU);
            @(posedge clock);
        end
        issue_instr(r_ins(5'd7, 5'd7, 5'd9, 5'd0, 6'h22));
        idle(4);

        // Flush during stall: lw $11,0x1234($0); dependent add pending while
        // out_ready=0; flush must produce a bubble and drop the add.
        exp_q.push_back(e_i(6'h23, 5'd0, 5'd11, 5'd11, 16'h1234, 8'h83));
        exp_q.push_back('0);
        exp_q.push_back(e_j(6'h02, 26'h0ABCDE));
        issue_instr(i_ins(6'h23, 5'd0, 5'd11, 16'h1234));
        @(negedge clock);
        in_valid = 1'b1; in_instr = r_ins(5'd11, 5'd11, 5'd12, 5'd0, 6'h20);
        out_ready = 1'b0; flush = 1'b1;
        #1;
        check("flush_hazard", hazard, 1'b1);
        check("flush_in_ready", in_ready, 1'b0);
        @(posedge clock);
        issue_instr(j_ins(6'h02, 26'h0ABCDE));
        idle(4);

        // Register 0 never stalls; jal -> jr $31; then sll and sw.
        for (int k = 0; k < 3; k++) exp_q.push_back(e_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h20));
        exp_q.push_back(e_j(6'h03, 26'h000100));
        push_bubbles(NB_JR);
        exp_q.push_back(e_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08));
        exp_q.push_back(e_r(5'd0, 5'd9, 5'd10, 5'd4, 6'h00));
        exp_q.push_back(e_i(6'h2b, 5'd6, 5'd5, 5'd0, 16'd4, 8'h03));
        for (int k = 0; k < 3; k++) issue_instr(r_ins(5'd0, 5'd0, 5'd0, 5'd0, 6'h20));
        issue_instr(j_ins(6'h03, 26'h000100));
        issue_instr(r_ins(5'd31, 5'd0, 5'd0, 5'd0, 6'h08));
        issue_instr(r_ins(5'd0, 5'd9, 5'd10, 5'd4, 6'h00));
        issue_instr(i_ins(6'h2b, 5'd6, 5'd5, 16'd4));
        idle(2);

        @(negedge clock);
        check("expected_queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_id_scoreboard_stage.md
IF_ID_SCOREBOARD_STAGE -- requirements
Module: if_id_scoreboard_stage

Interface
REQ-001 Parameter DEPTH, default 3: number of in-flight destination entries tracked, legal 1..8.
REQ-002 Parameter LINK_REG, default 31: destination register written by jal.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  fetch presents an instruction.
REQ-006 in_instr  input  32  MIPS instruction word.
REQ-007 in_ready  output  1  instruction accepted this edge; combinational: out_ready & !hazard & !flush.
REQ-008 out_ready  input  1  downstream stage can take a new decoded instruction.
REQ-009 flush  input  1  taken branch/jump; discard current slot.
REQ-010 out_valid  output  1  decoded fields are a real instruction; 0 means bubble.
REQ-011 opcode 6, rs 5, rt 5, rd 5, func 6, shamt 5, immediate 16, address 26: registered outputs, decoded fields.
REQ-012 controller  output  8  bit7 = mem-read (lw), bits1:0 = 2'b11 for a valid instruction, 0 for a bubble, all other bits 0.
REQ-013 hazard  output  1  combinational: in_valid & in_instr's sources match a tracked entry.

Function
REQ-014 Source usage is decoded as follows:
- op 0, func 000000/000010/000011 (shifts): rt only.
- op 0, func 001000 (jr): rs only.
- Other op 0: rs and rt.
- op[5:3]=001 (immediates) and lw 100011: rs.
- beq 000100, bne 000101, sw 101011: rs and rt.
- j 000010, jal 000011: none.
REQ-015 Destination decode: R-type rd (jr: none); immediates and lw: rt; jal: LINK_REG; all others: none.
REQ-016 A source equal to register 0 never causes a hazard.
REQ-017 The scoreboard is DEPTH entries of {valid, dest, is_load}; entry 0 is the youngest.
REQ-018 Advance condition: out_ready=1 or flush=1. On advance, entry i takes entry i-1, entry 0 takes the issued instruction's destination or an invalid entry, and entry DEPTH-1 is discarded.
REQ-019 Issue on advance when in_valid & !hazard & !flush: outputs load the decoded fields, out_valid=1. Unused fields are 0. For R-type, rd=instr[15:11]. For I-type and lw, rd=rt. For j/jal, only address is loaded.
REQ-020 When advancing without an issue: the bubble output is all fields 0, controller 0, out_valid 0, and an invalid scoreboard entry is pushed.
REQ-021 When out_ready=0 and flush=0: all outputs and the scoreboard hold, and in_ready=0.
REQ-022 flush has priority over issue and over out_ready=0: a bubble is output next edge and the scoreboard shifts.
REQ-023 Latency is 1 clock from acceptance to out_valid; throughput is 1 per clock with no hazards.
REQ-024 A simultaneous hazard and out_ready=1 inserts exactly one bubble per cycle until the matching entry ages out.
REQ-025 Destination register 0 is pushed as an invalid entry.

Reset
REQ-026 At a clock edge with reset=0: all outputs 0, out_valid 0, controller 0, all scoreboard entries invalid. Reset overrides flush and out_ready.
REQ-027 in_ready is 0 while reset=0.
REQ-028 An instruction presented during the reset edge is dropped and not accepted.

Configuration
REQ-029 Macro IFID_BYPASS_EN, when defined: only a matching valid entry 0 with is_load=1 raises hazard (load-use), and all other matches are assumed forwarded.
REQ-030 Without IFID_BYPASS_EN: any valid entry match in 0..DEPTH-1 raises hazard.

Verification
REQ-031 Reset: hold reset=0 for 2 clocks with in_valid=1 -> all outputs 0, in_ready=0, then the first instruction issues 1 clock after release.
REQ-032 Back-to-back: add $3,$1,$2 then add $5,$3,$4, DEPTH=3, no bypass -> 3 bubbles between them (2 with DEPTH=2). With IFID_BYPASS_EN -> 0 bubbles.
REQ-033 Load-use: lw $4,0($1) then add $6,$4,$4 with IFID_BYPASS_EN -> exactly 1 bubble, and the lw output has controller=8'h83.
REQ-034 Back-pressure: out_ready=0 for 4 clocks mid-stream -> outputs and hazard state frozen, in_ready=0, no instruction lost or duplicated.
REQ-035 Flush during stall: flush=1 while out_ready=0 and a hazard is pending -> next edge out_valid=0, and the pending instruction is not issued.
REQ-036 Register 0 and jal: add $0,$0,$0 repeated -> no bubbles. jal then jr $31 -> jr stalls DEPTH cycles without bypass.
